// File: rtl/mr1_dbus_responder_if.sv
// Interface carrying the MR1 dBus command/response signals.
// The master modport is the initiator side (MR1 core or bench).
// The slave modport is the responder side.
interface mr1_dbus_responder_if;
  logic        dBus_cmd_valid;
  logic        dBus_cmd_ready;
  logic        dBus_cmd_payload_wr;
  logic [31:0] dBus_cmd_payload_address;
  logic [31:0] dBus_cmd_payload_data;
  logic [1:0]  dBus_cmd_payload_size;
  logic        dBus_rsp_ready;
  logic [31:0] dBus_rsp_data;
  logic        dBus_rsp_error;

  modport master (
    output dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
           dBus_cmd_payload_data, dBus_cmd_payload_size,
    input  dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_data, dBus_rsp_error
  );

  modport slave (
    input  dBus_cmd_valid, dBus_cmd_payload_wr, dBus_cmd_payload_address,
           dBus_cmd_payload_data, dBus_cmd_payload_size,
    output dBus_cmd_ready, dBus_rsp_ready, dBus_rsp_data, dBus_rsp_error
  );
endinterface

// File: rtl/mr1_dbus_responder.sv
// MR1 dBus responder: word-addressed RAM that serves load/store commands.
// A load produces a one-cycle rsp_ready pulse RSP_LATENCY cycles after it fires.
// A store updates the RAM on its fire edge and produces no response.
// Optional feature macro: MR1_DBUS_RSP_ERROR_EN. When it is defined, the block
// flags reserved sizes, misaligned accesses and out-of-range addresses.
module mr1_dbus_responder #(
  parameter int          MEM_WORDS_LOG2 = 10,
  parameter int          RSP_LATENCY    = 1,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  mr1_dbus_responder_if.slave   dbus
);

  localparam int         DEPTH  = 1 << MEM_WORDS_LOG2;
  localparam logic [2:0] LAT_M1 = 3'(RSP_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  logic [31:0] mem [DEPTH];

  state_e                    state_q, state_d;
  logic                      cmd_ready_q, cmd_ready_d;
  logic                      rsp_ready_q, rsp_ready_d;
  logic [31:0]               rsp_data_q, rsp_data_d;
  logic                      rsp_error_q, rsp_error_d;
  logic [2:0]                cnt_q, cnt_d;
  logic [MEM_WORDS_LOG2-1:0] idx_q, idx_d;
  logic                      err_q, err_d;

  logic [31:0]               offset;
  logic [MEM_WORDS_LOG2-1:0] cmd_idx;
  logic [1:0]                lane;
  logic                      fire;
  logic                      access_err;
  logic                      mem_we;
  logic [3:0]                byte_en;
  logic [31:0]               wr_data;
  logic                      unused_ok;

  // Decode the command: word index, lane enables, replicated store data, error.
  always_comb begin
    // NOTE: every variable written in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    offset  = dbus.dBus_cmd_payload_address - BASE_ADDR;
    cmd_idx = offset[MEM_WORDS_LOG2+1:2];
    lane    = dbus.dBus_cmd_payload_address[1:0];
    fire    = dbus.dBus_cmd_valid && cmd_ready_q;
    byte_en = 4'b1111;
    wr_data = dbus.dBus_cmd_payload_data;
    case (dbus.dBus_cmd_payload_size)
      2'd0: begin
        byte_en = 4'b0001 << lane;
        wr_data = {4{dbus.dBus_cmd_payload_data[7:0]}};
      end
      2'd1: begin
        byte_en = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{dbus.dBus_cmd_payload_data[15:0]}};
      end
      default: ;
    endcase
`ifdef MR1_DBUS_RSP_ERROR_EN
    access_err = (dbus.dBus_cmd_payload_size == 2'd3)
              || (dbus.dBus_cmd_payload_size == 2'd1 && lane[0])
              || (dbus.dBus_cmd_payload_size == 2'd2 && lane != 2'd0)
              || (|offset[31:MEM_WORDS_LOG2+2]);
`else
    access_err = 1'b0;
`endif
    mem_we = fire && dbus.dBus_cmd_payload_wr && (state_q == IDLE) && !access_err;
  end

  // Offset bits outside the word index only matter when range checking is on.
  assign unused_ok = ^{offset[31:MEM_WORDS_LOG2+2], offset[1:0]};

  // Store path: byte-lane writes into the RAM on the store's fire edge.
  // NOTE: the RAM has no reset; its contents survive reset by design and a
  // reset branch would prevent mapping it onto a memory macro.
  always_ff @(posedge clock) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && byte_en[b]) mem[cmd_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  // Next-state logic for the IDLE -> WAIT -> RESP load sequence.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_ready_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_error_d = 1'b0;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (fire && !dbus.dBus_cmd_payload_wr) begin
          idx_d       = cmd_idx;
          err_d       = access_err;
          cnt_d       = LAT_M1;
          cmd_ready_d = 1'b0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        cmd_ready_d = 1'b0;
        if (cnt_q == 3'd0) begin
          rsp_ready_d = 1'b1;
          rsp_data_d  = err_q ? 32'h0 : mem[idx_q];
          rsp_error_d = err_q;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered bus outputs.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; the comb block above uses blocking ones.
    if (reset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_ready_q <= 1'b0;
      rsp_data_q  <= 32'h0;
      rsp_error_q <= 1'b0;
      cnt_q       <= 3'd0;
      idx_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_ready_q <= rsp_ready_d;
      rsp_data_q  <= rsp_data_d;
      rsp_error_q <= rsp_error_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
    end
  end

  assign dbus.dBus_cmd_ready = cmd_ready_q;
  assign dbus.dBus_rsp_ready = rsp_ready_q;
  assign dbus.dBus_rsp_data  = rsp_data_q;
  assign dbus.dBus_rsp_error = rsp_error_q;

endmodule

// File: tb/tb_mr1_dbus_responder.sv
// Bench for mr1_dbus_responder: two instances (latency 1 and latency 4) share
// clock and reset. Directed commands push expected responses into per-bus
// queues; a monitor pops and compares whenever rsp_ready is seen high.
module tb_mr1_dbus_responder;

  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } rsp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  rsp_t q_a[$];
  rsp_t q_b[$];
  rsp_t ea, eb;

  mr1_dbus_responder_if ifa ();
  mr1_dbus_responder_if ifb ();

  mr1_dbus_responder #(.MEM_WORDS_LOG2(10), .RSP_LATENCY(LAT_A), .BASE_ADDR(32'h0)) dut_a (
    .clock (clock),
    .reset (reset),
    .dbus  (ifa.slave)
  );

  mr1_dbus_responder #(.MEM_WORDS_LOG2(10), .RSP_LATENCY(LAT_B), .BASE_ADDR(32'h0)) dut_b (
    .clock (clock),
    .reset (reset),
    .dbus  (ifb.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic rdy(input int b);
    return (b == 0) ? ifa.dBus_cmd_ready : ifb.dBus_cmd_ready;
  endfunction

  task automatic drive(input int b, input logic v, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] size);
    if (b == 0) begin
      ifa.dBus_cmd_valid = v; ifa.dBus_cmd_payload_wr = wr; ifa.dBus_cmd_payload_address = addr;
      ifa.dBus_cmd_payload_data = data; ifa.dBus_cmd_payload_size = size;
    end else begin
      ifb.dBus_cmd_valid = v; ifb.dBus_cmd_payload_wr = wr; ifb.dBus_cmd_payload_address = addr;
      ifb.dBus_cmd_payload_data = data; ifb.dBus_cmd_payload_size = size;
    end
  endtask

  // Called at a negedge; returns at the negedge after the fire edge.
  task automatic issue(input int b, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] size, input bit exp_rsp, input logic [31:0] exp_data,
                       input logic exp_err, output int fire_cyc);
    rsp_t e;
    int   n;
    drive(b, 1'b1, wr, addr, data, size);
    n = 0;
    while (!rdy(b) && n < 100) begin
      @(negedge clock);
      n++;
    end
    fire_cyc = cyc + 1;
    if (!rdy(b)) begin
      checks++;
      errors++;
      $display("FAIL cmd_ready_timeout: bus %0d got ready=0 for 100 cycles expected 1", b);
    end else if (!wr && exp_rsp) begin
      e.data = exp_data;
      e.err  = exp_err;
      e.cyc  = fire_cyc + ((b == 0) ? LAT_A : LAT_B);
      if (b == 0) q_a.push_back(e); else q_b.push_back(e);
    end
    @(posedge clock);
    @(negedge clock);
    drive(b, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
  endtask

  task automatic st(input int b, input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
    int f;
    issue(b, 1'b1, addr, data, size, 1'b0, 32'h0, 1'b0, f);
  endtask

  task automatic ld(input int b, input logic [31:0] addr, input logic [31:0] exp_data, input logic exp_err);
    int f;
    issue(b, 1'b0, addr, 32'h0, 2'd2, 1'b1, exp_data, exp_err, f);
  endtask

  // Response monitors: every rsp pulse must match the head of its queue.
  always @(negedge clock) begin
    if (!reset && ifa.dBus_rsp_ready) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_rsp: got pulse at cycle %0d expected none", cyc);
      end else begin
        ea = q_a.pop_front();
        check("a_rsp_data", ifa.dBus_rsp_data, ea.data);
        check("a_rsp_error", {31'b0, ifa.dBus_rsp_error}, {31'b0, ea.err});
        check("a_rsp_cycle", 32'(cyc), 32'(ea.cyc));
      end
    end
    if (!reset && ifb.dBus_rsp_ready) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_rsp: got pulse at cycle %0d expected none", cyc);
      end else begin
        eb = q_b.pop_front();
        check("b_rsp_data", ifb.dBus_rsp_data, eb.data);
        check("b_rsp_error", {31'b0, ifb.dBus_rsp_error}, {31'b0, eb.err});
        check("b_rsp_cycle", 32'(cyc), 32'(eb.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int f1, f2, f3, fx;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);

    // Reset state, then ready one edge after release.
    repeat (2) @(negedge clock);
    check("rst_cmd_ready", {31'b0, ifa.dBus_cmd_ready}, 32'h0);
    check("rst_rsp_ready", {31'b0, ifa.dBus_rsp_ready}, 32'h0);
    check("rst_rsp_data", ifa.dBus_rsp_data, 32'h0);
    check("rst_rsp_error", {31'b0, ifa.dBus_rsp_error}, 32'h0);
    reset = 1'b0;
    #1 check("rel_ready_low", {31'b0, ifa.dBus_cmd_ready}, 32'h0);
    @(posedge clock); #1;
    check("rel_ready_high", {31'b0, ifa.dBus_cmd_ready}, 32'h1);
    check("rel_ready_high_b", {31'b0, ifb.dBus_cmd_ready}, 32'h1);
    @(negedge clock);

    // Word store then load with latency 1; ready timing around the load.
    st(0, 32'h10, 32'hDEADBEEF, 2'd2);
    check("ready_after_store", {31'b0, ifa.dBus_cmd_ready}, 32'h1);
    ld(0, 32'h10, 32'hDEADBEEF, 1'b0);
    check("ready_wait", {31'b0, ifa.dBus_cmd_ready}, 32'h0);
    @(negedge clock);
    check("ready_resp", {31'b0, ifa.dBus_cmd_ready}, 32'h0);
    @(negedge clock);
    check("ready_back", {31'b0, ifa.dBus_cmd_ready}, 32'h1);

    // Load accepted, reset asserted mid-cycle before its response.
    issue(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0, fx);
    #2 reset = 1'b1;
    #1;
    check("midrst_cmd_ready", {31'b0, ifa.dBus_cmd_ready}, 32'h0);
    check("midrst_rsp_ready", {31'b0, ifa.dBus_rsp_ready}, 32'h0);
    check("midrst_rsp_data", ifa.dBus_rsp_data, 32'h0);
    check("midrst_rsp_error", {31'b0, ifa.dBus_rsp_error}, 32'h0);
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    #1 check("midrst_rel_low", {31'b0, ifa.dBus_cmd_ready}, 32'h0);
    @(posedge clock); #1;
    check("midrst_rel_high", {31'b0, ifa.dBus_cmd_ready}, 32'h1);
    @(negedge clock);
    ld(0, 32'h10, 32'hDEADBEEF, 1'b0);

    // Byte and half lane merges.
    st(0, 32'h10, 32'h11223344, 2'd2);
    st(0, 32'h13, 32'h000000AA, 2'd0);
    ld(0, 32'h10, 32'hAA223344, 1'b0);
    st(0, 32'h20, 32'h00000000, 2'd2);
    st(0, 32'h22, 32'h00005566, 2'd1);
    ld(0, 32'h20, 32'h55660000, 1'b0);
    st(0, 32'h30, 32'h00000000, 2'd2);
    st(0, 32'h30, 32'hFFFFFF01, 2'd0);
    st(0, 32'h31, 32'hFFFFFF02, 2'd0);
    st(0, 32'h32, 32'hFFFFFF03, 2'd0);
    ld(0, 32'h30, 32'h00030201, 1'b0);

    // Misaligned half, misaligned word load, out-of-range and reserved size.
    st(0, 32'h21, 32'h00007788, 2'd1);
    st(0, 32'h0, 32'h0BADF00D, 2'd2);
    st(0, 32'h1010, 32'hCAFEF00D, 2'd2);
    st(0, 32'h40, 32'h00000000, 2'd2);
    st(0, 32'h40, 32'h13572468, 2'd3);
`ifdef MR1_DBUS_RSP_ERROR_EN
    ld(0, 32'h20, 32'h55660000, 1'b0);
    ld(0, 32'h2, 32'h00000000, 1'b1);
    ld(0, 32'h10, 32'hAA223344, 1'b0);
    ld(0, 32'h1010, 32'h00000000, 1'b1);
    ld(0, 32'h40, 32'h00000000, 1'b0);
`else
    ld(0, 32'h20, 32'h55667788, 1'b0);
    ld(0, 32'h2, 32'h0BADF00D, 1'b0);
    ld(0, 32'h10, 32'hCAFEF00D, 1'b0);
    ld(0, 32'h1010, 32'hCAFEF00D, 1'b0);
    ld(0, 32'h40, 32'h13572468, 1'b0);
`endif

    // Back-to-back stores at one per cycle.
    issue(0, 1'b1, 32'h50, 32'h00000050, 2'd2, 1'b0, 32'h0, 1'b0, f1);
    issue(0, 1'b1, 32'h54, 32'h00000054, 2'd2, 1'b0, 32'h0, 1'b0, f2);
    issue(0, 1'b1, 32'h58, 32'h00000058, 2'd2, 1'b0, 32'h0, 1'b0, f3);
    check("b2b_gap1", 32'(f2 - f1), 32'd1);
    check("b2b_gap2", 32'(f3 - f2), 32'd1);
    ld(0, 32'h54, 32'h00000054, 1'b0);
    ld(0, 32'h58, 32'h00000058, 1'b0);

    // Latency 4 with the next load held valid through WAIT.
    st(1, 32'h10, 32'h12345678, 2'd2);
    st(1, 32'h14, 32'h9ABCDEF0, 2'd2);
    issue(1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b1, 32'h12345678, 1'b0, f1);
    issue(1, 1'b0, 32'h14, 32'h0, 2'd2, 1'b1, 32'h9ABCDEF0, 1'b0, f2);
    check("b_held_gap", 32'(f2 - f1), 32'(LAT_B + 2));
    // Back-to-back loads on bus A obey the same next-fire rule.
    issue(0, 1'b0, 32'h50, 32'h0, 2'd2, 1'b1, 32'h00000050, 1'b0, f1);
    issue(0, 1'b0, 32'h54, 32'h0, 2'd2, 1'b1, 32'h00000054, 1'b0, f2);
    check("a_held_gap", 32'(f2 - f1), 32'(LAT_A + 2));

    // Drain outstanding responses and watch for stray pulses.
    for (int n = 0; n < 200 && (q_a.size() != 0 || q_b.size() != 0); n++) @(negedge clock);
    check("queues_drained", 32'(q_a.size() + q_b.size()), 32'h0);
    repeat (10) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
